// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the LC-3b physical-memory arbiter and its optional counter bank.
package pmem_arbiter_pkg;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_line;

   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} pmem_arb_state_t;

   // MEM-stage address window where the arbiter counters appear.
   localparam lc3b_word    PERF_BASE = 16'hFFF6;
   localparam int unsigned PERF_NUM  = 4;

endpackage

// File: rtl/pmem_arb_perf.sv
// Saturating 16-bit counter bank with a combinational select mux.
// Only compiled when PMEM_ARB_PERF_EN is defined.
`ifdef PMEM_ARB_PERF_EN
module pmem_arb_perf
   import pmem_arbiter_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                perf_clr,
   input  logic [1:0]          perf_sel,
   input  logic [PERF_NUM-1:0] inc,
   output lc3b_word            perf_data
);

   lc3b_word cnt_q [PERF_NUM];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(PERF_NUM); k++) cnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < int'(PERF_NUM); k++) begin
            if (perf_clr) begin
               cnt_q[k] <= '0;
            end else if (inc[k] && (cnt_q[k] != 16'hFFFF)) begin
               cnt_q[k] <= cnt_q[k] + 16'd1;
            end
         end
      end
   end

   assign perf_data = cnt_q[perf_sel];

endmodule
`endif

// File: rtl/pmem_arbiter.sv
// Physical-memory port arbiter between icache and dcache, dcache-favoured with bounded starvation.
// Define PMEM_ARB_PERF_EN to build the performance counter bank.
module pmem_arbiter
   import pmem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     i_read,
   input  lc3b_word i_addr,
   output lc3b_line i_rdata,
   output logic     i_resp,
   input  logic     d_read,
   input  logic     d_write,
   input  lc3b_word d_addr,
   input  lc3b_line d_wdata,
   output lc3b_line d_rdata,
   output logic     d_resp,
   output logic     pmem_read,
   output logic     pmem_write,
   output lc3b_word pmem_addr,
   output lc3b_line pmem_wdata,
   input  lc3b_line pmem_rdata,
   input  logic     pmem_resp,
   input  logic [1:0] perf_sel,
   input  logic     perf_clr,
   output lc3b_word perf_data
);

   localparam int unsigned CntW = $clog2(STARVE_LIMIT + 2);
   localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

   pmem_arb_state_t state_q;
   logic [CntW-1:0] starve_q;

   logic d_req, both_req, force_i, go_i, go_d;

   assign d_req    = d_read | d_write;
   assign both_req = i_read & d_req;
   assign force_i  = both_req && (starve_q == Limit);
   assign go_d     = (state_q == IDLE) && d_req && !force_i;
   assign go_i     = (state_q == IDLE) && i_read && (!d_req || force_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         starve_q   <= '0;
         pmem_read  <= 1'b0;
         pmem_write <= 1'b0;
         pmem_addr  <= '0;
         pmem_wdata <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (go_d) begin
                  state_q    <= GRANT_D;
                  pmem_addr  <= d_addr;
                  pmem_wdata <= d_wdata;
                  // A writeback wins over a fill if the dcache raises both.
                  pmem_write <= d_write;
                  pmem_read  <= !d_write;
                  if (i_read && (starve_q != Limit)) starve_q <= starve_q + 1'b1;
               end else if (go_i) begin
                  state_q    <= GRANT_I;
                  pmem_addr  <= i_addr;
                  pmem_wdata <= '0;
                  pmem_read  <= 1'b1;
                  pmem_write <= 1'b0;
                  starve_q   <= '0;
               end
            end
            GRANT_I, GRANT_D: begin
               if (pmem_resp) begin
                  state_q    <= IDLE;
                  pmem_read  <= 1'b0;
                  pmem_write <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign i_resp  = (state_q == GRANT_I) && pmem_resp;
   assign d_resp  = (state_q == GRANT_D) && pmem_resp;
   assign i_rdata = i_resp ? pmem_rdata : '0;
   assign d_rdata = d_resp ? pmem_rdata : '0;

   d_op_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
      go_d |-> !(d_read && d_write));

`ifdef PMEM_ARB_PERF_EN
   pmem_arb_perf u_perf (
      .clk       (clk),
      .rst_n     (rst_n),
      .perf_clr  (perf_clr),
      .perf_sel  (perf_sel),
      .inc       ({go_i && d_req, both_req, go_d, go_i}),
      .perf_data (perf_data)
   );
`else
   logic unused_perf;
   assign unused_perf = ^{perf_sel, perf_clr};
   assign perf_data   = '0;
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomized bench for pmem_arbiter against a cycle-level behavioural model of the arbitration rules.
module tb_pmem_arbiter;

   localparam int unsigned LIMIT = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
   logic [15:0]  i_addr = '0, d_addr = '0;
   logic [127:0] d_wdata = '0, pmem_rdata = '0;
   logic         pmem_resp = 1'b0, perf_clr = 1'b0;
   logic [1:0]   perf_sel = '0;
   logic [127:0] i_rdata, d_rdata, pmem_wdata;
   logic         i_resp, d_resp, pmem_read, pmem_write;
   logic [15:0]  pmem_addr, perf_data;

   always #5 clk = ~clk;

   pmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_read     (i_read),
      .i_addr     (i_addr),
      .i_rdata    (i_rdata),
      .i_resp     (i_resp),
      .d_read     (d_read),
      .d_write    (d_write),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata),
      .d_resp     (d_resp),
      .pmem_read  (pmem_read),
      .pmem_write (pmem_write),
      .pmem_addr  (pmem_addr),
      .pmem_wdata (pmem_wdata),
      .pmem_rdata (pmem_rdata),
      .pmem_resp  (pmem_resp),
      .perf_sel   (perf_sel),
      .perf_clr   (perf_clr),
      .perf_data  (perf_data)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: owner 0=none 1=icache 2=dcache.
   int           m_owner, m_starve;
   logic         m_rd, m_wr;
   logic [15:0]  m_addr;
   logic [127:0] m_wdata;
   int           m_cnt [4];

   // Driver knobs and bookkeeping.
   int unsigned p_i = 0, p_d = 0, p_resp = 0;
   bit abandon_en = 0, d_hold = 0, perf_rand = 0;
   bit last_i_resp = 0, last_d_resp = 0;
   int n_i_resp = 0, n_d_resp = 0, n_d_at_first_i = -1;

   task automatic model_reset();
      m_owner = 0; m_starve = 0; m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
   endtask

   task automatic compare();
      bit exp_i, exp_d;
      logic [15:0] exp_perf;
      exp_i = (m_owner == 1) && pmem_resp;
      exp_d = (m_owner == 2) && pmem_resp;
`ifdef PMEM_ARB_PERF_EN
      exp_perf = 16'(m_cnt[perf_sel]);
`else
      exp_perf = 16'h0;
`endif
      check("pmem_read", 128'(pmem_read), 128'(m_rd));
      check("pmem_write", 128'(pmem_write), 128'(m_wr));
      check("i_resp", 128'(i_resp), 128'(exp_i));
      check("d_resp", 128'(d_resp), 128'(exp_d));
      check("perf_data", 128'(perf_data), 128'(exp_perf));
      if (m_owner != 0 || !rst_n) check("pmem_addr", 128'(pmem_addr), 128'(m_addr));
      if (m_wr || !rst_n) check("pmem_wdata", pmem_wdata, m_wdata);
      if (exp_i) check("i_rdata", i_rdata, pmem_rdata);
      if (exp_d) check("d_rdata", d_rdata, pmem_rdata);
      if (exp_i && n_i_resp == 0) n_d_at_first_i = n_d_resp;
      if (exp_i) n_i_resp++;
      if (exp_d) n_d_resp++;
      last_i_resp = exp_i;
      last_d_resp = exp_d;
   endtask

   task automatic bump(input int k, input bit cond);
      if (cond && m_cnt[k] < 65535) m_cnt[k]++;
   endtask

   task automatic step();
      bit dreq, both;
      int win;
      if (!rst_n) begin
         model_reset();
         return;
      end
      dreq = d_read || d_write;
      both = i_read && dreq;
      win  = 0;
      if (m_owner == 0) begin
         if (dreq && !(i_read && m_starve == int'(LIMIT))) win = 2;
         else if (i_read) win = 1;
      end
      if (perf_clr) begin
         for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      end else begin
         bump(0, win == 1);
         bump(1, win == 2);
         bump(2, both);
         bump(3, win == 1 && dreq);
      end
      if (m_owner != 0) begin
         if (pmem_resp) begin
            m_owner = 0; m_rd = 0; m_wr = 0;
         end
      end else if (win == 2) begin
         m_owner = 2; m_addr = d_addr; m_wdata = d_wdata; m_wr = d_write; m_rd = !d_write;
         if (i_read && m_starve < int'(LIMIT)) m_starve++;
      end else if (win == 1) begin
         m_owner = 1; m_addr = i_addr; m_wdata = '0; m_rd = 1; m_wr = 0; m_starve = 0;
      end
   endtask

   // Caller sits just after a negedge with inputs already driven.
   task automatic cycle();
      #1 compare();
      @(posedge clk);
      step();
      @(negedge clk);
   endtask

   task automatic drive_random();
      if (i_read) begin
         if (last_i_resp || (abandon_en && $urandom_range(0, 15) == 0)) i_read = 1'b0;
         else if ($urandom_range(0, 7) == 0) i_addr = 16'($urandom);
      end else if ($urandom_range(0, 99) < p_i) begin
         i_read = 1'b1;
         i_addr = 16'($urandom);
      end
      if (d_read || d_write) begin
         if ((last_d_resp && !d_hold) || (abandon_en && $urandom_range(0, 15) == 0)) begin
            d_read = 1'b0;
            d_write = 1'b0;
         end else if (last_d_resp || $urandom_range(0, 7) == 0) begin
            d_addr  = 16'($urandom);
            d_wdata = {$urandom, $urandom, $urandom, $urandom};
         end
      end else if ($urandom_range(0, 99) < p_d) begin
         d_write = 1'($urandom_range(0, 1));
         d_read  = !d_write;
         d_addr  = 16'($urandom);
         d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      pmem_resp  = ($urandom_range(0, 99) < p_resp);
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (perf_rand) begin
         perf_sel = 2'($urandom_range(0, 3));
         perf_clr = ($urandom_range(0, 99) == 0);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0; perf_clr = 0; perf_sel = 0;
      last_i_resp = 0; last_d_resp = 0;
      n_i_resp = 0; n_d_resp = 0; n_d_at_first_i = -1;
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
   endtask

   initial begin
      int guard;
      do_reset();
      check("rst_state_read", 128'(pmem_read), 128'(0));
      check("rst_state_addr", 128'(pmem_addr), 128'(0));

      // Single icache fill, memory answers three cycles into the grant.
      i_read = 1'b1; i_addr = 16'h0040;
      cycle();
      check("t1_strobe", 128'(pmem_read), 128'(1));
      check("t1_addr", 128'(pmem_addr), 128'(16'h0040));
      cycle();
      cycle();
      pmem_resp = 1'b1;
      #1 check("t1_iresp", 128'(i_resp), 128'(1));
      check("t1_dresp", 128'(d_resp), 128'(0));
      cycle();
      pmem_resp = 1'b0; i_read = 1'b0;
      cycle();
      check("t1_idle", 128'(pmem_read), 128'(0));

      // Simultaneous writeback and fill, both served in order.
      d_write = 1'b1; d_addr = 16'h0100; d_wdata = {4{32'hCAFE_F00D}}; i_read = 1'b1; i_addr = 16'h0200;
      cycle();
      check("t2_dfirst", 128'(pmem_write), 128'(1));
      check("t2_wdata", pmem_wdata, {4{32'hCAFE_F00D}});
      p_i = 100; p_d = 0; p_resp = 50;
      for (int n = 0; n < 30; n++) begin
         drive_random();
         cycle();
      end
      check("t2_iserved", 128'(n_i_resp > 0), 128'(1));

      // Starvation: dcache never drops, icache held.
      do_reset();
      p_i = 100; p_d = 100; p_resp = 100; d_hold = 1; abandon_en = 0; perf_rand = 0;
      guard = 0;
      while (n_i_resp < 1 && guard < 60) begin
         drive_random();
         cycle();
         guard++;
      end
      check("t3_igrant", 128'(n_i_resp), 128'(1));
      check("t3_d_before_i", 128'(n_d_at_first_i), 128'(LIMIT));
      perf_sel = 2'd3;
`ifdef PMEM_ARB_PERF_EN
      #1 check("t3_forced_cnt", 128'(perf_data), 128'(1));
`else
      #1 check("t3_forced_cnt", 128'(perf_data), 128'(0));
`endif
      d_hold = 0;

      // Reset while an icache fill is in flight.
      do_reset();
      i_read = 1'b1; i_addr = 16'h0777;
      cycle();
      cycle();
      #2 rst_n = 1'b0;
      model_reset();
      #1 check("t5_async_strobe", 128'(pmem_read), 128'(0));
      cycle();
      rst_n = 1'b1; i_read = 1'b0; pmem_resp = 1'b1;
      #1 check("t5_no_iresp", 128'(i_resp), 128'(0));
      cycle();
      pmem_resp = 1'b0;
      cycle();

      // Counter clear then three icache grants.
      perf_clr = 1'b1;
      cycle();
      perf_clr = 1'b0; perf_sel = 2'd0;
      p_i = 100; p_d = 0; p_resp = 100; n_i_resp = 0;
      guard = 0;
      while (n_i_resp < 3 && guard < 40) begin
         drive_random();
         cycle();
         guard++;
      end
      p_i = 0;
      drive_random();
      cycle();
`ifdef PMEM_ARB_PERF_EN
      #1 check("t6_igrants", 128'(perf_data), 128'(3));
`else
      #1 check("t6_igrants", 128'(perf_data), 128'(0));
`endif

      // Long random traffic with abandons, stray responses and counter churn.
      do_reset();
      p_i = 40; p_d = 50; p_resp = 30; abandon_en = 1; perf_rand = 1;
      for (int n = 0; n < 3000; n++) begin
         drive_random();
         cycle();
      end
      p_i = 70; p_d = 100; p_resp = 60; abandon_en = 0; d_hold = 1;
      for (int n = 0; n < 1500; n++) begin
         drive_random();
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
